// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage req/ack data-memory controller that stalls the pipeline while a transaction is outstanding.
// Optional MEM_ACCESS_STATS_EN adds stall_cnt_o and timeout_cnt_o statistics counters.
module mem_access_unit #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] Addr_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] MemData_o,
  output logic        stall_o,
  output logic        misalign_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
`ifdef MEM_ACCESS_STATS_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [15:0] timeout_cnt_o
`endif
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic access, expire;
  assign access     = (MemRead_i | MemWrite_i) & (Addr_i[1:0] == 2'b00);
  assign misalign_o = (MemRead_i | MemWrite_i) & (Addr_i[1:0] != 2'b00);
  assign stall_o    = (state == S_IDLE & access) | (state == S_WAIT);
  assign expire     = (state == S_WAIT) & ~mem_ack_i & (cnt == CW'(TIMEOUT - 1));
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      MemData_o   <= '0;
      err_o       <= 1'b0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      err_o <= 1'b0;
      case (state)
        S_IDLE: if (access) begin
          mem_addr_o  <= {Addr_i[31:2], 2'b00};
          mem_wdata_o <= WriteData_i;
          mem_we_o    <= MemWrite_i;
          mem_req_o   <= 1'b1;
          cnt         <= '0;
          state       <= S_WAIT;
        end
        S_WAIT: if (mem_ack_i) begin
          if (!mem_we_o) MemData_o <= mem_rdata_i;
          mem_req_o <= 1'b0;
          state     <= S_DONE;
        end else if (expire) begin
          MemData_o <= ERR_DATA;
          err_o     <= 1'b1;
          mem_req_o <= 1'b0;
          state     <= S_DONE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
`ifdef MEM_ACCESS_STATS_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_o   <= '0;
      timeout_cnt_o <= '0;
    end else begin
      if (stall_o) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (expire && timeout_cnt_o != 16'hFFFF) timeout_cnt_o <= timeout_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  logic clk = 1'b0, rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0, ack = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata = '0;
  logic [31:0] mem_data, mem_addr, mem_wdata;
  logic stall, misalign, err, req, we;
`ifdef MEM_ACCESS_STATS_EN
  logic [31:0] stall_cnt;
  logic [15:0] timeout_cnt;
`endif
  int errors = 0, checks = 0, s1, s2;
  always #5 clk = ~clk;
  mem_access_unit dut (
    .clk_i(clk), .rst_i(rst), .MemRead_i(rd), .MemWrite_i(wr), .Addr_i(addr),
    .WriteData_i(wdata), .MemData_o(mem_data), .stall_o(stall), .misalign_o(misalign),
    .err_o(err), .mem_req_o(req), .mem_we_o(we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_ack_i(ack), .mem_rdata_i(rdata)
`ifdef MEM_ACCESS_STATS_EN
    , .stall_cnt_o(stall_cnt), .timeout_cnt_o(timeout_cnt)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  // Starts in the IDLE cycle of a request; returns at the DONE negedge with the stall-cycle count.
  task automatic txn(input int ack_at, output int stalls);
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      ack = (ack_at != 0) && (k == ack_at);
      @(negedge clk);
      if (!stall) break;
      stalls++;
      cyc();
    end
    ack = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_data", mem_data, 32'h0);
    chk("rst_req", {31'b0, req}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    cyc();
    rd = 1'b1; addr = 32'h40; rdata = 32'h12345678;
    txn(3, s1);
    chk("ld_stalls", s1, 4);
    chk("ld_data", mem_data, 32'h12345678);
    chk("ld_addr", mem_addr, 32'h40);
    chk("ld_we", {31'b0, we}, 32'h0);
    chk("ld_req", {31'b0, req}, 32'h0);
    chk("ld_err", {31'b0, err}, 32'h0);
    rd = 1'b0; cyc();
    wr = 1'b1; addr = 32'h80; wdata = 32'hCAFEF00D; rdata = 32'hFFFFFFFF;
    txn(1, s1);
    chk("st_stalls", s1, 2);
    chk("st_we", {31'b0, we}, 32'h1);
    chk("st_wdata", mem_wdata, 32'hCAFEF00D);
    chk("st_addr", mem_addr, 32'h80);
    chk("st_data", mem_data, 32'h12345678);
    wr = 1'b0; cyc();
    ack = 1'b1; rdata = 32'h11111111;
    @(negedge clk);
    chk("idle_ack_stall", {31'b0, stall}, 32'h0);
    cyc(); ack = 1'b0;
    @(negedge clk);
    chk("idle_ack_data", mem_data, 32'h12345678);
    chk("idle_ack_req", {31'b0, req}, 32'h0);
    cyc();
    rd = 1'b1; addr = 32'h41;
    @(negedge clk);
    chk("mis_flag", {31'b0, misalign}, 32'h1);
    chk("mis_stall", {31'b0, stall}, 32'h0);
    cyc();
    @(negedge clk);
    chk("mis_req", {31'b0, req}, 32'h0);
    chk("mis_data", mem_data, 32'h12345678);
    rd = 1'b0; cyc();
    rd = 1'b1; addr = 32'hC0; rdata = 32'h55555555;
    txn(0, s1);
    chk("to_stalls", s1, 17);
    chk("to_err", {31'b0, err}, 32'h1);
    chk("to_data", mem_data, 32'hDEADBEEF);
    chk("to_req", {31'b0, req}, 32'h0);
    rd = 1'b0; cyc();
    @(negedge clk);
    chk("to_err_pulse", {31'b0, err}, 32'h0);
`ifdef MEM_ACCESS_STATS_EN
    chk("to_cnt", {16'b0, timeout_cnt}, 32'h1);
`endif
    cyc();
    rd = 1'b1; addr = 32'hC4; rdata = 32'h600DF00D;
    txn(16, s1);
    chk("ack16_stalls", s1, 17);
    chk("ack16_err", {31'b0, err}, 32'h0);
    chk("ack16_data", mem_data, 32'h600DF00D);
    rd = 1'b0; cyc();
    rd = 1'b1; addr = 32'h100;
    cyc(); cyc();
    rst = 1'b1; rd = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", {31'b0, req}, 32'h0);
    chk("mid_rst_data", mem_data, 32'h0);
    chk("mid_rst_stall", {31'b0, stall}, 32'h0);
    cyc();
    rd = 1'b1; addr = 32'h0; rdata = 32'hA0A0A0A0;
    txn(1, s1);
    chk("b2b1_stalls", s1, 2);
    chk("b2b1_data", mem_data, 32'hA0A0A0A0);
    chk("b2b1_req", {31'b0, req}, 32'h0);
    addr = 32'h4; rdata = 32'hB0B0B0B0;
    cyc();
    txn(1, s2);
    chk("b2b2_stalls", s2, 2);
    chk("b2b2_data", mem_data, 32'hB0B0B0B0);
    chk("b2b2_addr", mem_addr, 32'h4);
`ifdef MEM_ACCESS_STATS_EN
    chk("b2b_stall_cnt", stall_cnt, 32'd4);
    chk("b2b_timeout_cnt", {16'b0, timeout_cnt}, 32'h0);
`endif
    rd = 1'b0; cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
